// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: sram-like bus bundle, N lanes wide, with master/slave views
interface sram_like_arbiter_if #(parameter int N = 1);
  logic [N-1:0] req;
  logic [N-1:0] wr;
  logic [2*N-1:0] size;
  logic [4*N-1:0] wstrb;
  logic [32*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic [N-1:0] addr_ok;
  logic [N-1:0] data_ok;
  logic [31:0] rdata;
  modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges N_CH sram-like masters onto one slave, routing responses in order via an ID FIFO
module sram_like_arbiter #(
  parameter int N_CH = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE = 0
) (
  input logic clk,
  input logic reset,
  sram_like_arbiter_if.slave ch,
  sram_like_arbiter_if.master m,
  output logic busy,
  output logic proto_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IW = $clog2(N_CH);
  logic [IW-1:0] fifo [MAX_OUTSTANDING];
  logic [IW-1:0] lock_ch, rr_ptr, g, j;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic lock_vld, gv, pop, accept, full;
  always_comb begin
    gv = 1'b0;
    g = '0;
    j = '0;
    if (lock_vld) begin
      gv = 1'b1;
      g = lock_ch;
    end else if (ARB_MODE == 0) begin
      for (int i = N_CH - 1; i >= 0; i--)
        if (ch.req[IW'(i)]) begin
          gv = 1'b1;
          g = IW'(i);
        end
    end else begin
      for (int k = N_CH; k >= 1; k--) begin
        j = IW'((int'(rr_ptr) + k) % N_CH);
        if (ch.req[j]) begin
          gv = 1'b1;
          g = j;
        end
      end
    end
  end
  assign full = cnt == CW'(MAX_OUTSTANDING);
  assign pop = m.data_ok[0] & |cnt;
  assign m.req = |ch.req & ~(full & ~pop) & ~reset;
  assign accept = m.req[0] & m.addr_ok[0];
  assign m.wr = gv & ch.wr[g];
  assign m.size = gv ? 2'(ch.size >> (2 * g)) : '0;
  assign m.wstrb = gv ? 4'(ch.wstrb >> (4 * g)) : '0;
  assign m.addr = gv ? 32'(ch.addr >> (32 * g)) : '0;
  assign m.wdata = gv ? 32'(ch.wdata >> (32 * g)) : '0;
  assign ch.addr_ok = accept ? N_CH'(1) << g : '0;
  assign ch.data_ok = pop ? N_CH'(1) << fifo[rp] : '0;
  assign ch.rdata = m.rdata;
  assign busy = |cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      lock_vld <= 1'b0;
      lock_ch <= '0;
      rr_ptr <= IW'(N_CH - 1);
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        fifo[wp] <= g;
        wp <= wp == PW'(MAX_OUTSTANDING - 1) ? '0 : wp + PW'(1);
        lock_vld <= 1'b0;
        rr_ptr <= g;
      end else if (m.req[0]) begin
        lock_vld <= 1'b1;
        lock_ch <= g;
      end
      if (pop)
        rp <= rp == PW'(MAX_OUTSTANDING - 1) ? '0 : rp + PW'(1);
      if (m.data_ok[0] & ~|cnt)
        proto_err <= 1'b1;
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end
endmodule
